// File: rtl/pixel_framebuffer_if.sv
// Write-side request/handshake and VGA read-side bundle for pixel_framebuffer.
// The master drives paint/clear requests and scan coordinates; the slave is the framebuffer.
interface pixel_framebuffer_if #(
  parameter int FB_W      = 160,
  parameter int FB_H      = 120,
  parameter int COLOR_W   = 3,
  parameter int BRUSH_MAX = 3
);
  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int RW = $clog2(BRUSH_MAX + 1);

  logic               brush;
  logic               clear;
  logic [COLOR_W-1:0] newColor;
  logic [XW-1:0]      wx;
  logic [YW-1:0]      wy;
  logic [RW-1:0]      radius;
  logic [9:0]         rx;
  logic [9:0]         ry;
  logic [COLOR_W-1:0] colorCode;
  logic               busy;
  logic               done;

  modport master (
    output brush, clear, newColor, wx, wy, radius, rx, ry,
    input  colorCode, busy, done
  );

  modport slave (
    input  brush, clear, newColor, wx, wy, radius, rx, ry,
    output colorCode, busy, done
  );
endinterface

// File: rtl/pixel_framebuffer.sv
// Downscaled FB_W x FB_H framebuffer: brush-stamp / clear FSM on the write port, VGA scan read port.
// Define BRUSH_ROUND_EN for a round brush; otherwise the brush is square.
module pixel_framebuffer #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int COLOR_W     = 3,
  parameter int SCALE_SHIFT = 2,
  parameter int BRUSH_MAX   = 3
) (
  input logic                clk,
  input logic                reset,
  pixel_framebuffer_if.slave fb
);
  localparam int XW   = $clog2(FB_W);
  localparam int YW   = $clog2(FB_H);
  localparam int RW   = $clog2(BRUSH_MAX + 1);
  localparam int XS   = XW + 1;
  localparam int YS   = YW + 1;
  localparam int NPIX = FB_W * FB_H;
  localparam int AW   = $clog2(NPIX);

  localparam logic signed [XW:0] FbWX      = XS'(FB_W);
  localparam logic signed [YW:0] FbHY      = YS'(FB_H);
  localparam logic [AW-1:0]      FbWA      = AW'(FB_W);
  localparam logic [AW-1:0]      LastAddr  = AW'(NPIX - 1);
  localparam logic [RW-1:0]      BrushMaxR = RW'(BRUSH_MAX);
  localparam logic [9:0]         FbW10     = 10'(FB_W);
  localparam logic [9:0]         FbH10     = 10'(FB_H);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  function automatic logic [AW-1:0] pixAddr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * FbWA + AW'(x);
  endfunction

  function automatic logic [RW-1:0] clampRadius(input logic [RW-1:0] rq);
    return (rq > BrushMaxR) ? BrushMaxR : rq;
  endfunction

`ifdef BRUSH_ROUND_EN
  function automatic logic withinRadius(input logic signed [XW:0] ddx,
                                        input logic signed [YW:0] ddy,
                                        input logic [RW-1:0]      rr);
    int sx;
    int sy;
    int sr;
    sx = int'(ddx);
    sy = int'(ddy);
    sr = int'(rr);
    return (sx * sx + sy * sy) <= (sr * sr);
  endfunction
`endif

  state_t               state;
  logic [COLOR_W-1:0]   mem [NPIX];

  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic [COLOR_W-1:0]   color;
  logic [RW-1:0]        r;
  logic signed [XW:0]   dx;
  logic signed [YW:0]   dy;
  logic [AW-1:0]        clrAddr;

  logic [RW-1:0]        rClamp;
  logic signed [XW:0]   rX;
  logic signed [YW:0]   rY;
  logic signed [XW:0]   px;
  logic signed [YW:0]   py;
  logic                 pixIn;
  logic                 shapeOk;
  logic                 paintEnd;
  logic                 we;
  logic [AW-1:0]        wAddr;

  logic [9:0]           fx;
  logic [9:0]           fy;
  logic                 rdIn;
  logic [AW-1:0]        rdAddr;

  assign rClamp   = clampRadius(fb.radius);
  assign rX       = $signed(XS'(r));
  assign rY       = $signed(YS'(r));
  // Candidate pixel uses one extra sign bit so negative offsets near the edge clip instead of wrapping.
  assign px       = $signed({1'b0, cx}) + dx;
  assign py       = $signed({1'b0, cy}) + dy;
  assign pixIn    = !px[XW] && (px < FbWX) && !py[YW] && (py < FbHY);
  assign paintEnd = (dx == rX) && (dy == rY);

`ifdef BRUSH_ROUND_EN
  assign shapeOk = withinRadius(dx, dy, r);
`else
  assign shapeOk = 1'b1;
`endif

  always_comb begin
    we    = 1'b0;
    wAddr = clrAddr;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (state == PAINT) begin
      we    = pixIn && shapeOk;
      wAddr = pixAddr(px[XW-1:0], py[YW-1:0]);
    end
  end

  // Control: state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fb.busy <= 1'b0;
      fb.done <= 1'b0;
    end else begin
      fb.done <= 1'b0;
      case (state)
        IDLE: begin
          if (fb.clear) begin
            state   <= CLEAR;
            fb.busy <= 1'b1;
          end else if (fb.brush) begin
            state   <= PAINT;
            fb.busy <= 1'b1;
          end
        end
        PAINT: begin
          if (paintEnd) begin
            state   <= IDLE;
            fb.busy <= 1'b0;
            fb.done <= 1'b1;
          end
        end
        CLEAR: begin
          if (clrAddr == LastAddr) begin
            state   <= IDLE;
            fb.busy <= 1'b0;
            fb.done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          fb.busy <= 1'b0;
        end
      endcase
    end
  end

  // Operands reload every idle cycle, so the values present on the accepting edge are the ones kept.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        cx      <= fb.wx;
        cy      <= fb.wy;
        color   <= fb.newColor;
        r       <= rClamp;
        dx      <= -$signed(XS'(rClamp));
        dy      <= -$signed(YS'(rClamp));
        clrAddr <= '0;
      end
      PAINT: begin
        if (dx == rX) begin
          dx <= -rX;
          dy <= dy + YS'(1);
        end else begin
          dx <= dx + XS'(1);
        end
      end
      CLEAR: clrAddr <= clrAddr + AW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= color;
  end

  // Read stage: downscale the VGA coordinate, then register the pixel (old data on a same-address write).
  assign fx     = fb.rx >> SCALE_SHIFT;
  assign fy     = fb.ry >> SCALE_SHIFT;
  assign rdIn   = (fx < FbW10) && (fy < FbH10);
  assign rdAddr = pixAddr(fx[XW-1:0], fy[YW-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fb.colorCode <= '0;
    else       fb.colorCode <= rdIn ? mem[rdAddr] : '0;
  end
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench for pixel_framebuffer: reset, clear, brush stamping, clipping, priority, abort.
module tb_pixel_framebuffer;
  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  pixel_framebuffer_if fbIf ();

  pixel_framebuffer dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // All tasks are entered and left on a falling clock edge.
  task automatic readRaw(input int x, input int y, output logic [2:0] c);
    fbIf.rx = 10'(x);
    fbIf.ry = 10'(y);
    @(negedge clk);
    c = fbIf.colorCode;
  endtask

  task automatic startOp(input logic doClear, input logic doBrush, input logic [2:0] col,
                         input int x, input int y, input logic [1:0] rad);
    fbIf.clear    = doClear;
    fbIf.brush    = doBrush;
    fbIf.newColor = col;
    fbIf.wx       = 8'(x);
    fbIf.wy       = 7'(y);
    fbIf.radius   = rad;
    @(negedge clk);
    fbIf.clear = 1'b0;
    fbIf.brush = 1'b0;
  endtask

  task automatic waitOp(input int bound, output int cycles, output logic doneSeen);
    cycles = 0;
    while (fbIf.busy === 1'b1 && cycles < bound) begin
      cycles++;
      @(negedge clk);
    end
    doneSeen = fbIf.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fbIf.brush = 1'b0; fbIf.clear = 1'b0; fbIf.newColor = 3'd0;
    fbIf.wx = 8'd0; fbIf.wy = 7'd0; fbIf.radius = 2'd0;
    fbIf.rx = 10'd0; fbIf.ry = 10'd0;
    repeat (3) @(negedge clk);
    vecs++; if (fbIf.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", fbIf.busy); end
    vecs++; if (fbIf.done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b expected 0", fbIf.done); end
    vecs++; if (fbIf.colorCode !== 3'd0) begin errs++; $display("FAIL rst_color: got %b expected 000", fbIf.colorCode); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int cyc; logic dn; int bad; logic [2:0] c;
    startOp(1'b1, 1'b0, 3'b101, 0, 0, 2'd0);
    waitOp(20000, cyc, dn);
    vecs++; if (cyc !== 19200) begin errs++; $display("FAIL clr_busy: got %0d cycles expected 19200", cyc); end
    vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL clr_done: got %b expected 1", dn); end
    @(negedge clk);
    vecs++; if (fbIf.done !== 1'b0) begin errs++; $display("FAIL clr_done_once: got %b expected 0", fbIf.done); end
    bad = 0;
    for (int fy = 0; fy < 120; fy++)
      for (int fx = 0; fx < 160; fx++) begin
        readRaw(fx * 4 + (fx % 4), fy * 4 + ((fx + fy) % 4), c);
        if (c !== 3'b101) bad++;
      end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL clr_frame: got %0d bad pixels expected 0", bad); end
    readRaw(700, 0, c);
    vecs++; if (c !== 3'd0) begin errs++; $display("FAIL clr_rx700: got %b expected 000", c); end
    readRaw(0, 500, c);
    vecs++; if (c !== 3'd0) begin errs++; $display("FAIL clr_ry500: got %b expected 000", c); end
    readRaw(639, 479, c);
    vecs++; if (c !== 3'b101) begin errs++; $display("FAIL clr_lastpix: got %b expected 101", c); end
  endtask

  task automatic test_single_pixel();
    int cyc; logic dn; int bad; logic [2:0] c;
    startOp(1'b0, 1'b1, 3'b010, 100, 100, 2'd0);
    waitOp(10, cyc, dn);
    vecs++; if (cyc !== 1) begin errs++; $display("FAIL px_busy: got %0d cycles expected 1", cyc); end
    vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL px_done: got %b expected 1", dn); end
    bad = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) begin
        readRaw(400 + i, 400 + j, c);
        if (c !== 3'b010) bad++;
      end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL px_block: got %0d bad reads expected 0", bad); end
    readRaw(404, 400, c);
    vecs++; if (c !== 3'b101) begin errs++; $display("FAIL px_right: got %b expected 101", c); end
    readRaw(400, 404, c);
    vecs++; if (c !== 3'b101) begin errs++; $display("FAIL px_below: got %b expected 101", c); end
  endtask

  task automatic test_edge_clip();
    int cyc; logic dn; logic [2:0] c;
    int xs [12];
    int ys [12];
    logic [2:0] ex [12];
    xs = '{0, 2, 0, 1, 3, 0, 159, 159, 0, 2, 158, 159};
    ys = '{0, 2, 2, 1, 0, 3, 0, 2, 119, 119, 118, 119};
    ex = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101,
           3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
    startOp(1'b0, 1'b1, 3'b110, 0, 0, 2'd2);
    waitOp(100, cyc, dn);
    vecs++; if (cyc !== 25) begin errs++; $display("FAIL clip_busy: got %0d cycles expected 25", cyc); end
    vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL clip_done: got %b expected 1", dn); end
    for (int k = 0; k < 12; k++) begin
      readRaw(xs[k] * 4, ys[k] * 4, c);
      vecs++;
      if (c !== ex[k]) begin
        errs++;
        $display("FAIL clip_pix(%0d,%0d): got %b expected %b", xs[k], ys[k], c, ex[k]);
      end
    end
  endtask

  task automatic test_priority();
    int cyc; int dones; int bad; logic [2:0] c;
    fbIf.brush = 1'b1; fbIf.clear = 1'b1; fbIf.newColor = 3'b011;
    fbIf.wx = 8'd10; fbIf.wy = 7'd10; fbIf.radius = 2'd1;
    @(negedge clk);
    fbIf.brush = 1'b0; fbIf.clear = 1'b0;
    cyc = 0; dones = 0;
    while (fbIf.busy === 1'b1 && cyc < 20000) begin
      cyc++;
      fbIf.brush = (cyc == 50);
      if (cyc == 50) begin fbIf.newColor = 3'b111; fbIf.wx = 8'd20; fbIf.wy = 7'd20; end
      @(negedge clk);
      if (fbIf.done === 1'b1) dones++;
    end
    fbIf.brush = 1'b0;
    vecs++; if (cyc !== 19200) begin errs++; $display("FAIL prio_busy: got %0d cycles expected 19200", cyc); end
    vecs++; if (dones !== 1) begin errs++; $display("FAIL prio_done: got %0d pulses expected 1", dones); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fbIf.busy !== 1'b0) bad++;
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL prio_no_paint: got %0d busy cycles expected 0", bad); end
    readRaw(80, 80, c);
    vecs++; if (c !== 3'b011) begin errs++; $display("FAIL prio_pix20: got %b expected 011", c); end
    readRaw(40, 40, c);
    vecs++; if (c !== 3'b011) begin errs++; $display("FAIL prio_pix10: got %b expected 011", c); end
  endtask

  task automatic test_clamp();
    int cyc; logic dn; logic [2:0] c; int req; logic [2:0] cornerExp;
`ifdef BRUSH_ROUND_EN
    cornerExp = 3'b011;
`else
    cornerExp = 3'b111;
`endif
    // Radius port is two bits wide here, so a request of 7 arrives as 3 (== BRUSH_MAX).
    req = 7;
    startOp(1'b0, 1'b1, 3'b111, 50, 50, req[1:0]);
    waitOp(200, cyc, dn);
    vecs++; if (cyc !== 49) begin errs++; $display("FAIL clamp_busy: got %0d cycles expected 49", cyc); end
    vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL clamp_done: got %b expected 1", dn); end
    readRaw(53 * 4, 50 * 4, c);
    vecs++; if (c !== 3'b111) begin errs++; $display("FAIL clamp_p3_0: got %b expected 111", c); end
    readRaw(50 * 4, 47 * 4, c);
    vecs++; if (c !== 3'b111) begin errs++; $display("FAIL clamp_0_m3: got %b expected 111", c); end
    readRaw(52 * 4, 52 * 4, c);
    vecs++; if (c !== 3'b111) begin errs++; $display("FAIL clamp_p2_p2: got %b expected 111", c); end
    readRaw(54 * 4, 50 * 4, c);
    vecs++; if (c !== 3'b011) begin errs++; $display("FAIL clamp_p4_0: got %b expected 011", c); end
    readRaw(53 * 4, 53 * 4, c);
    vecs++; if (c !== cornerExp) begin errs++; $display("FAIL clamp_corner_pp: got %b expected %b", c, cornerExp); end
    readRaw(47 * 4, 47 * 4, c);
    vecs++; if (c !== cornerExp) begin errs++; $display("FAIL clamp_corner_mm: got %b expected %b", c, cornerExp); end
    readRaw(53 * 4, 52 * 4, c);
    vecs++; if (c !== cornerExp) begin errs++; $display("FAIL clamp_p3_p2: got %b expected %b", c, cornerExp); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc; logic dn; logic [2:0] c;
    fbIf.rx = 10'd40; fbIf.ry = 10'd40;
    startOp(1'b1, 1'b0, 3'b100, 0, 0, 2'd0);
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vecs++; if (fbIf.busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b expected 0", fbIf.busy); end
    vecs++; if (fbIf.colorCode !== 3'd0) begin errs++; $display("FAIL abort_color: got %b expected 000", fbIf.colorCode); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    readRaw(200, 0, c);
    vecs++; if (c !== 3'b100) begin errs++; $display("FAIL abort_addr50: got %b expected 100", c); end
    readRaw(396, 0, c);
    vecs++; if (c !== 3'b100) begin errs++; $display("FAIL abort_addr99: got %b expected 100", c); end
    readRaw(400, 0, c);
    vecs++; if (c !== 3'b011) begin errs++; $display("FAIL abort_addr100: got %b expected 011", c); end
    readRaw(160, 4, c);
    vecs++; if (c !== 3'b011) begin errs++; $display("FAIL abort_addr200: got %b expected 011", c); end
    startOp(1'b0, 1'b1, 3'b001, 5, 5, 2'd0);
    vecs++; if (fbIf.busy !== 1'b1) begin errs++; $display("FAIL abort_accept: got %b expected 1", fbIf.busy); end
    waitOp(10, cyc, dn);
    vecs++; if (cyc !== 1) begin errs++; $display("FAIL abort_brush_busy: got %0d cycles expected 1", cyc); end
    readRaw(20, 20, c);
    vecs++; if (c !== 3'b001) begin errs++; $display("FAIL abort_brush_pix: got %b expected 001", c); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_clear();
    test_single_pixel();
    test_edge_clip();
    test_priority();
    test_clamp();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
Parametrised successor to the fixed 3-bit pixel store. Holds a downscaled framebuffer of FB_W x FB_H pixels, COLOR_W bits each. Write side: a paint FSM stamps a variable-radius brush, clipped at the edges, or clears the whole screen. Read side: VGA-resolution coordinates from the VGA controller, mapped through a power-of-two downscale, with registered colour output.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
COLOR_W, 3, bits per pixel
SCALE_SHIFT, 2, VGA-to-framebuffer downscale (fx = rx >> SCALE_SHIFT)
BRUSH_MAX, 3, maximum brush radius; larger requests clamp to this
XW, $clog2(FB_W), framebuffer x width (derived)
YW, $clog2(FB_H), framebuffer y width (derived)
RW, $clog2(BRUSH_MAX+1), radius width (derived)

Ports:
clk  input  1  system clock, single domain
reset  input  1  asynchronous, active-high reset
brush  input  1  paint request; sampled each cycle, honoured only when busy=0
clear  input  1  clear request; sampled each cycle, honoured only when busy=0
newColor  input  COLOR_W  paint/clear colour, latched on accept
wx  input  XW  brush centre x (framebuffer units)
wy  input  YW  brush centre y
radius  input  RW  brush radius, latched on accept
rx  input  10  VGA pixel x
ry  input  10  VGA pixel y
colorCode  output  COLOR_W  pixel colour at (rx,ry), 1-cycle latency
busy  output  1  FSM in PAINT or CLEAR
done  output  1  one-cycle pulse on the cycle after the last write of an operation

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; busy=0, done=0, colorCode=0. Memory contents are not cleared by reset.
- FSM states: IDLE, PAINT, CLEAR.
- IDLE -> CLEAR: clear=1. Latch newColor; address counter = 0.
- IDLE -> PAINT: brush=1 and clear=0. Latch wx, wy, newColor and min(radius, BRUSH_MAX) as r; dx = dy = -r.
- Priority: clear beats brush when both are asserted in the same cycle.
- Requests arriving while busy=1 are dropped and not queued.
- PAINT timing: one candidate pixel per cycle at (cx+dx, cy+dy), signed arithmetic one bit wider than XW/YW.
  - Write only if 0 <= x < FB_W and 0 <= y < FB_H; otherwise skip the write but still spend the cycle.
  - Scan order: dx increments first; when dx = r, dx wraps to -r and dy increments.
  - After (r, r): return to IDLE and pulse done.
  - Busy duration is exactly (2r+1)^2 cycles; r=0 gives a 1-cycle single-pixel write.
- CLEAR: write the latched colour to addresses 0 .. FB_W*FB_H-1, one per cycle. Busy lasts FB_W*FB_H cycles, then IDLE with a done pulse.
- Address: addr = y*FB_W + x, width $clog2(FB_W*FB_H).
- Read path, independent dual-port, always active:
  - fx = rx >> SCALE_SHIFT, fy = ry >> SCALE_SHIFT.
  - If fx < FB_W and fy < FB_H: colorCode <= mem[fy*FB_W+fx] on the next clock edge.
  - Otherwise colorCode <= 0, also registered.
- Read-during-write to the same address returns the old data; the new data is visible from the following cycle.
- Reset mid-PAINT or mid-CLEAR: abort immediately, busy=0. Pixels already written remain written.

Optional Feature:
Macro BRUSH_ROUND_EN.
- Defined: round brush. In PAINT, the write is also suppressed when dx*dx + dy*dy > r*r, so corner pixels are skipped. Cycle count is unchanged at (2r+1)^2, and edge clipping still applies.
- Undefined: square brush, with every in-bounds candidate written.

Test Plan:
- Reset, then brush with wx=100, wy=100, r=0, newColor=010: busy high 1 cycle, done pulse next cycle. Driving rx=400..403, ry=400..403 returns colorCode=010 one cycle later; rx=404, ry=400 returns the prior colour.
- brush at wx=0, wy=0, r=2, colour 110: busy exactly 25 cycles. (0,0), (2,2) and (0,2) read 110; (3,0) is unchanged; no wrap writes appear at (159,*) or (*,119).
- clear, colour 101: busy exactly 19200 cycles, done once. A full VGA frame reads 101 everywhere for ry<480, and 0 at rx=700 or ry=500.
- brush and clear asserted in the same cycle: clear runs. A brush pulse mid-clear is ignored, and no PAINT follows the done pulse.
- radius=7 with BRUSH_MAX=3: busy 49 cycles, clamped to r=3. With BRUSH_ROUND_EN defined, the (+3,+3) corner is not written and (+3,0) is written.
- reset asserted 100 cycles into a clear: busy=0 and colorCode=0 asynchronously. Address 50 holds the new colour, address 200 the old colour, and a new brush is accepted after reset deasserts.
